// File: rtl/rf_wb_arb_if.sv
// Write-back request/grant bus for rf_wb_arb: three requesters in, one register-file write out.
// Forwarding signals exist only when RF_WB_ARB_BYPASS_EN is defined.
interface rf_wb_arb_if;
    logic        a_valid;
    logic [4:0]  a_rc;
    logic [31:0] a_data;
    logic        a_ready;
    logic        l_valid;
    logic [4:0]  l_rc;
    logic [31:0] l_data;
    logic        l_ready;
    logic        x_valid;
    logic [31:0] x_data;
    logic        x_ready;
    logic        werf;
    logic        wasel;
    logic [4:0]  rc;
    logic [31:0] wdata;
    logic [4:0]  pend_rc;
    logic        pend_v;
`ifdef RF_WB_ARB_BYPASS_EN
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [31:0] fwd_data;
`endif

    modport master (
        output a_valid, a_rc, a_data, l_valid, l_rc, l_data, x_valid, x_data,
`ifdef RF_WB_ARB_BYPASS_EN
        output qa, qb,
        input  fwd_a_hit, fwd_b_hit, fwd_data,
`endif
        input  a_ready, l_ready, x_ready, werf, wasel, rc, wdata, pend_rc, pend_v
    );

    modport slave (
        input  a_valid, a_rc, a_data, l_valid, l_rc, l_data, x_valid, x_data,
`ifdef RF_WB_ARB_BYPASS_EN
        input  qa, qb,
        output fwd_a_hit, fwd_b_hit, fwd_data,
`endif
        output a_ready, l_ready, x_ready, werf, wasel, rc, wdata, pend_rc, pend_v
    );
endinterface

// File: rtl/rf_wb_arb.sv
// Register-file write-back arbiter: exception > round-robin(ALU, load), one registered write per cycle.
// Optional macro RF_WB_ARB_BYPASS_EN adds forwarding-hit outputs against the pending write.
module rf_wb_arb #(
    parameter int unsigned XP_REG = 30
) (
    input logic         clk,
    input logic         reset,
    rf_wb_arb_if.slave  bus
);
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam logic [RW-1:0] ZERO_RC = RW'(31);
    localparam logic [RW-1:0] XP_RC   = RW'(XP_REG);

    logic          rr_q, rr_d;
    logic          a_gnt, l_gnt, x_gnt;
    logic          werf_q, werf_d;
    logic          wasel_q, wasel_d;
    logic [RW-1:0] rc_q, rc_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // Grant selection and round-robin pointer update; nothing granted during reset.
    always_comb begin
        a_gnt = 1'b0;
        l_gnt = 1'b0;
        x_gnt = 1'b0;
        rr_d  = rr_q;
        if (!reset) begin
            if (bus.x_valid) begin
                x_gnt = 1'b1;
            end else if (bus.a_valid && bus.l_valid) begin
                // Under contention the pointer moves to the loser.
                if (rr_q) begin
                    a_gnt = 1'b1;
                    rr_d  = 1'b0;
                end else begin
                    l_gnt = 1'b1;
                    rr_d  = 1'b1;
                end
            end else if (bus.a_valid) begin
                a_gnt = 1'b1;
            end else if (bus.l_valid) begin
                l_gnt = 1'b1;
            end
        end
    end

    // Next write-port contents; idle cycles keep address/data/select and drop the enable.
    always_comb begin
        werf_d  = 1'b0;
        wasel_d = wasel_q;
        rc_d    = rc_q;
        wdata_d = wdata_q;
        if (x_gnt) begin
            werf_d  = 1'b1;
            wasel_d = 1'b1;
            rc_d    = XP_RC;
            wdata_d = bus.x_data;
        end else if (a_gnt) begin
            werf_d  = (bus.a_rc != ZERO_RC);
            wasel_d = 1'b0;
            rc_d    = bus.a_rc;
            wdata_d = bus.a_data;
        end else if (l_gnt) begin
            werf_d  = (bus.l_rc != ZERO_RC);
            wasel_d = 1'b0;
            rc_d    = bus.l_rc;
            wdata_d = bus.l_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= 1'b0;
            werf_q  <= 1'b0;
            wasel_q <= 1'b0;
            rc_q    <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            werf_q  <= werf_d;
            wasel_q <= wasel_d;
            rc_q    <= rc_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.a_ready = a_gnt;
    assign bus.l_ready = l_gnt;
    assign bus.x_ready = x_gnt;
    assign bus.werf    = werf_q;
    assign bus.wasel   = wasel_q;
    assign bus.rc      = rc_q;
    assign bus.wdata   = wdata_q;
    assign bus.pend_v  = werf_q;
    assign bus.pend_rc = rc_q;

`ifdef RF_WB_ARB_BYPASS_EN
    // R31 never forwards: it reads as zero regardless of what is pending.
    assign bus.fwd_a_hit = werf_q && (bus.qa == rc_q) && (bus.qa != ZERO_RC);
    assign bus.fwd_b_hit = werf_q && (bus.qb == rc_q) && (bus.qb != ZERO_RC);
    assign bus.fwd_data  = wdata_q;
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb: vector table for arbitration/write-port behaviour, plus
// hand sequences for reset discarding an accepted write and the optional forwarding path.
module tb_rf_wb_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rf_wb_arb_if bus ();
    rf_wb_arb #(.XP_REG(30)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        rst;
        logic        av;
        logic [4:0]  arc;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrc;
        logic [31:0] ld;
        logic        xv;
        logic [31:0] xd;
        logic [2:0]  rdy;   // {a, l, x}
        logic        w;
        logic        ws;
        logic [4:0]  rc;
        logic [31:0] wd;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] arc,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lrc,
                                input logic [31:0] ld, input logic xv, input logic [31:0] xd,
                                input logic [2:0] rdy, input logic w, input logic ws,
                                input logic [4:0] rc, input logic [31:0] wd);
        vec_t v;
        v.rst = rst; v.av = av; v.arc = arc; v.ad = ad;
        v.lv = lv; v.lrc = lrc; v.ld = ld; v.xv = xv; v.xd = xd;
        v.rdy = rdy; v.w = w; v.ws = ws; v.rc = rc; v.wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset       = v.rst;
        bus.a_valid = v.av;
        bus.a_rc    = v.arc;
        bus.a_data  = v.ad;
        bus.l_valid = v.lv;
        bus.l_rc    = v.lrc;
        bus.l_data  = v.ld;
        bus.x_valid = v.xv;
        bus.x_data  = v.xd;
    endtask

    function automatic logic [63:0] ready_now();
        return 64'({bus.a_ready, bus.l_ready, bus.x_ready});
    endfunction

    // {werf, wasel, rc, wdata, pend_v, pend_rc}
    function automatic logic [63:0] port_now();
        return 64'({bus.werf, bus.wasel, bus.rc, bus.wdata, bus.pend_v, bus.pend_rc});
    endfunction

    function automatic logic [63:0] port_exp(input logic w, input logic ws,
                                             input logic [4:0] rc, input logic [31:0] wd);
        return 64'({w, ws, rc, wd, w, rc});
    endfunction

    initial begin
        vec_t idle;
        idle = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        apply(idle);
        reset = 1'b1;
`ifdef RF_WB_ARB_BYPASS_EN
        bus.qa = 5'd0;
        bus.qb = 5'd0;
`endif
        // Reset held with A pending, then normal operation.
        vecs[0]  = mk(1, 1, 9,  32'h99,   0, 0,  32'h0,  0, 32'h0,   3'b000, 0, 0, 0,  32'h0);
        vecs[1]  = mk(1, 1, 9,  32'h99,   0, 0,  32'h0,  0, 32'h0,   3'b000, 0, 0, 0,  32'h0);
        vecs[2]  = mk(0, 1, 9,  32'h99,   0, 0,  32'h0,  0, 32'h0,   3'b100, 1, 0, 9,  32'h99);
        vecs[3]  = mk(0, 0, 0,  32'h0,    0, 0,  32'h0,  0, 32'h0,   3'b000, 0, 0, 9,  32'h99);
        // Contention alternates L, A, L from RR=0.
        vecs[4]  = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b010, 1, 0, 4,  32'h22);
        vecs[5]  = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b100, 1, 0, 3,  32'h11);
        vecs[6]  = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b010, 1, 0, 4,  32'h22);
        // X wins over both; RR stays pointing at A.
        vecs[7]  = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 1, 32'h100, 3'b001, 1, 1, 30, 32'h100);
        vecs[8]  = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b100, 1, 0, 3,  32'h11);
        // Write to R31 is consumed without enabling the register file.
        vecs[9]  = mk(0, 1, 31, 32'hDEAD, 0, 0,  32'h0,  0, 32'h0,   3'b100, 0, 0, 31, 32'hDEAD);
        // Uncontended L leaves RR=0, so next contention grants L.
        vecs[10] = mk(0, 0, 0,  32'h0,    1, 4,  32'h22, 0, 32'h0,   3'b010, 1, 0, 4,  32'h22);
        vecs[11] = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b010, 1, 0, 4,  32'h22);
        vecs[12] = mk(0, 0, 0,  32'h0,    1, 31, 32'h5,  0, 32'h0,   3'b010, 0, 0, 31, 32'h5);
        vecs[13] = mk(0, 0, 0,  32'h0,    0, 0,  32'h0,  1, 32'hABC, 3'b001, 1, 1, 30, 32'hABC);
        vecs[14] = mk(0, 0, 0,  32'h0,    0, 0,  32'h0,  0, 32'h0,   3'b000, 0, 1, 30, 32'hABC);
        vecs[15] = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b100, 1, 0, 3,  32'h11);
        // Reset with everyone valid, then RR restarts at L.
        vecs[16] = mk(1, 1, 3,  32'h11,   1, 4,  32'h22, 1, 32'h100, 3'b000, 0, 0, 0,  32'h0);
        vecs[17] = mk(0, 1, 3,  32'h11,   1, 4,  32'h22, 0, 32'h0,   3'b010, 1, 0, 4,  32'h22);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("ready[%0d]", i), ready_now(), 64'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("wport[%0d]", i), port_now(),
                  port_exp(vecs[i].w, vecs[i].ws, vecs[i].rc, vecs[i].wd));
        end

        // Accept A(R5), then reset: the pending write must be dropped at the reset edge.
        @(negedge clk);
        apply(idle);
        bus.a_valid = 1'b1;
        bus.a_rc    = 5'd5;
        bus.a_data  = 32'h55;
        #1;
        check("r5_ready", ready_now(), 64'(3'b100));
        @(posedge clk);
        #1;
        check("r5_write", port_now(), port_exp(1'b1, 1'b0, 5'd5, 32'h55));
        @(negedge clk);
        apply(idle);
        reset = 1'b1;
        #1;
        check("rst_ready", ready_now(), 64'(3'b000));
        @(posedge clk);
        #1;
        check("rst_drop", port_now(), port_exp(1'b0, 1'b0, 5'd0, 32'h0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", port_now(), port_exp(1'b0, 1'b0, 5'd0, 32'h0));

`ifdef RF_WB_ARB_BYPASS_EN
        // Pending L(R7) forwards to QA=7; QB=31 never hits.
        @(negedge clk);
        apply(idle);
        bus.l_valid = 1'b1;
        bus.l_rc    = 5'd7;
        bus.l_data  = 32'h55;
        bus.qa      = 5'd7;
        bus.qb      = 5'd31;
        @(posedge clk);
        #1;
        check("fwd_hits", 64'({bus.fwd_a_hit, bus.fwd_b_hit}), 64'(2'b10));
        check("fwd_data", 64'(bus.fwd_data), 64'h55);
        @(negedge clk);
        apply(idle);
        bus.qb = 5'd7;
        #1;
        check("fwd_b_hit", 64'({bus.fwd_a_hit, bus.fwd_b_hit}), 64'(2'b11));
        @(posedge clk);
        #1;
        check("fwd_idle", 64'({bus.fwd_a_hit, bus.fwd_b_hit}), 64'(2'b00));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
